// File: rtl/clk_pkg.sv
// Shared definitions for the DCM lock sequencer: one-hot state codes,
// retry counter width and the counter sizing helper.
package clk_pkg;

    localparam int RETRY_W = 4;

    localparam logic [5:0] ST_RESET_DCM = 6'b000001;
    localparam logic [5:0] ST_WAIT_LOCK = 6'b000010;
    localparam logic [5:0] ST_SETTLE    = 6'b000100;
    localparam logic [5:0] ST_RELEASE   = 6'b001000;
    localparam logic [5:0] ST_RUN       = 6'b010000;
    localparam logic [5:0] ST_FAIL      = 6'b100000;

    typedef enum logic [5:0] {
        RESET_DCM = ST_RESET_DCM,
        WAIT_LOCK = ST_WAIT_LOCK,
        SETTLE    = ST_SETTLE,
        RELEASE   = ST_RELEASE,
        RUN       = ST_RUN,
        FAIL      = ST_FAIL
    } state_t;

    // One counter serves every state, so size it for the longest interval.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for bringing asynchronous levels into the
// local clock domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/dcm_lock_sequencer.sv
// Clock bring-up controller: pulses the DCM reset, waits for lock with a
// bounded retry budget, then releases the downstream reset domains in turn.
module dcm_lock_sequencer
    import clk_pkg::*;
#(
    parameter int RST_PULSE_CYC = 4,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int SETTLE_CYC    = 256,
    parameter int N_CHAN        = 4,
    parameter int STAGGER_CYC   = 16,
    parameter int MAX_RETRY     = 7
) (
    input  logic               fclk,
    input  logic               rst,
    input  logic               locked,
    output logic               dcm_rst,
    output logic [N_CHAN-1:0]  chan_rst,
    output logic               ready,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic               fail,
    output logic               lock_lost
);

    localparam int CNT_W = cnt_width(RST_PULSE_CYC, LOCK_TIMEOUT, SETTLE_CYC,
                                     N_CHAN * STAGGER_CYC);
    localparam logic [CNT_W-1:0] C_PULSE_END   = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT_END = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_SETTLE_END  = CNT_W'(SETTLE_CYC - 1);

    state_t             r_state, w_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_CHAN-1:0]  r_chan_rst, w_chan_nxt;
    logic [RETRY_W-1:0] r_retry, w_retry_nxt, w_retry_inc;
    logic               r_dcm_rst, r_ready, r_fail, r_lock_lost;
    logic               w_locked_s, w_lost_set, w_attempt_fail;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .i_clk (fclk),
        .i_rst (rst),
        .i_d   (locked),
        .o_q   (w_locked_s)
    );

    assign w_retry_inc = (r_retry == '1) ? r_retry : r_retry + RETRY_W'(1);

    always_comb begin
        w_nxt          = r_state;
        w_chan_nxt     = r_chan_rst;
        w_retry_nxt    = r_retry;
        w_lost_set     = 1'b0;
        w_attempt_fail = 1'b0;
        case (r_state)
            RESET_DCM: if (r_cnt == C_PULSE_END) w_nxt = WAIT_LOCK;
            // Lock seen on the timeout cycle still wins.
            WAIT_LOCK: begin
                if (w_locked_s)                  w_nxt = SETTLE;
                else if (r_cnt == C_TIMEOUT_END) w_attempt_fail = 1'b1;
            end
            SETTLE: begin
                if (!w_locked_s) begin
                    w_lost_set     = 1'b1;
                    w_attempt_fail = 1'b1;
                end else if (r_cnt == C_SETTLE_END) begin
                    w_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (!w_locked_s) begin
                    w_lost_set = 1'b1;
                    w_nxt      = RESET_DCM;
                end else if (!r_chan_rst[N_CHAN-1]) begin
                    w_nxt       = RUN;
                    w_retry_nxt = '0;
                end else begin
                    for (int i = 0; i < N_CHAN; i++)
                        if (r_cnt == CNT_W'(i * STAGGER_CYC)) w_chan_nxt[i] = 1'b0;
                end
            end
            RUN: begin
                if (!w_locked_s) begin
                    w_lost_set = 1'b1;
                    w_nxt      = RESET_DCM;
                end
            end
            FAIL:    w_nxt = FAIL;
            default: w_nxt = RESET_DCM;
        endcase
        if (w_attempt_fail) begin
            w_retry_nxt = w_retry_inc;
            w_nxt = (MAX_RETRY != 0 && int'(w_retry_inc) == MAX_RETRY) ? FAIL : RESET_DCM;
        end
        if (w_nxt == RESET_DCM || w_nxt == FAIL) w_chan_nxt = '1;
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            r_state     <= RESET_DCM;
            r_cnt       <= '0;
            r_dcm_rst   <= 1'b1;
            r_chan_rst  <= '1;
            r_ready     <= 1'b0;
            r_retry     <= '0;
            r_fail      <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (w_nxt != r_state)
                r_cnt <= '0;
            else if (r_state != RUN && r_state != FAIL)
                r_cnt <= r_cnt + CNT_W'(1);
            r_dcm_rst   <= (w_nxt == RESET_DCM) || (w_nxt == FAIL);
            r_chan_rst  <= w_chan_nxt;
            r_ready     <= (w_nxt == RUN);
            r_retry     <= w_retry_nxt;
            r_fail      <= (w_nxt == FAIL);
            r_lock_lost <= r_lock_lost | w_lost_set;
        end
    end

    assign dcm_rst   = r_dcm_rst;
    assign chan_rst  = r_chan_rst;
    assign ready     = r_ready;
    assign retry_cnt = r_retry;
    assign fail      = r_fail;
    assign lock_lost = r_lock_lost;

endmodule

// File: tb/tb_dcm_lock_sequencer.sv
// Scoreboard bench for dcm_lock_sequencer: stimulus queues each expected
// output change with its edge number; a negedge monitor pops and compares.
module tb_dcm_lock_sequencer;

    localparam int NC = 3;

    logic          fclk = 1'b0;
    logic          rst = 1'b1;
    logic          locked = 1'b0;
    logic          dcm_rst;
    logic [NC-1:0] chan_rst;
    logic          ready;
    logic [3:0]    retry_cnt;
    logic          fail;
    logic          lock_lost;

    dcm_lock_sequencer #(
        .RST_PULSE_CYC (4),
        .LOCK_TIMEOUT  (100),
        .SETTLE_CYC    (20),
        .N_CHAN        (NC),
        .STAGGER_CYC   (5),
        .MAX_RETRY     (2)
    ) dut (
        .fclk      (fclk),
        .rst       (rst),
        .locked    (locked),
        .dcm_rst   (dcm_rst),
        .chan_rst  (chan_rst),
        .ready     (ready),
        .retry_cnt (retry_cnt),
        .fail      (fail),
        .lock_lost (lock_lost)
    );

    always #5 fclk = ~fclk;

    int cyc = 0;
    always @(posedge fclk) cyc <= cyc + 1;

    typedef struct {
        string       nm;
        logic [10:0] v;
        int          c;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [10:0] obs;
    logic [10:0] prev = 'x;

    // {dcm_rst, chan_rst[2:0], ready, retry_cnt[3:0], fail, lock_lost}
    assign obs = {dcm_rst, chan_rst, ready, retry_cnt, fail, lock_lost};

    function automatic logic [10:0] ov(int d, int ch, int r, int rc, int f, int l);
        return {d[0], ch[2:0], r[0], rc[3:0], f[0], l[0]};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic push(string nm, logic [10:0] v, int c);
        sb_q.push_back('{nm, v, c});
    endtask

    always @(negedge fclk) begin
        if (rst) begin
            prev = obs;
        end else if (obs !== prev) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_change: got 0x%0h at edge %0d, expected 0x%0h held", obs, cyc, prev);
            end else begin
                e = sb_q.pop_front();
                chk(e.nm, 32'(obs), 32'(e.v));
                chk({e.nm, "_edge"}, cyc, e.c);
            end
            prev = obs;
        end
    end

    task automatic wait_until(int c);
        while (cyc < c) begin
            @(posedge fclk);
            #1;
        end
    endtask

    task automatic drain(string nm);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(posedge fclk);
            #1;
            n++;
        end
        chk(nm, sb_q.size(), 0);
    endtask

    // Reset is asserted between edges; values are checked before the next edge.
    task automatic do_reset(string nm, output int r);
        @(posedge fclk);
        #1;
        rst    = 1'b1;
        locked = 1'b0;
        #1;
        chk(nm, 32'(obs), 32'(ov(1, 3'b111, 0, 0, 0, 0)));
        repeat (3) @(posedge fclk);
        #1;
        rst = 1'b0;
        r   = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected summary");
        $fatal(1);
    end

    initial begin
        int r, l, d;

        // Nominal bringup. L = first edge sampling locked=1; chan0 clears at
        // L+23 (2 sync edges, detect edge, 20 settle edges, first release edge).
        do_reset("reset_initial", r);
        l = r + 14;
        push("s1_dcm_fall", ov(0, 3'b111, 0, 0, 0, 0), r + 4);
        push("s1_ch0",      ov(0, 3'b110, 0, 0, 0, 0), l + 23);
        push("s1_ch1",      ov(0, 3'b100, 0, 0, 0, 0), l + 28);
        push("s1_ch2",      ov(0, 3'b000, 0, 0, 0, 0), l + 33);
        push("s1_ready",    ov(0, 3'b000, 1, 0, 0, 0), l + 34);
        wait_until(l - 1); locked = 1'b1;
        wait_until(l + 40);
        drain("s1_drain");

        // One-cycle lock drop in RUN, seen after the synchroniser.
        d = l + 45;
        push("s4_lost",     ov(1, 3'b111, 0, 0, 0, 1), d + 2);
        push("s4_dcm_fall", ov(0, 3'b111, 0, 0, 0, 1), d + 6);
        push("s4_ch0",      ov(0, 3'b110, 0, 0, 0, 1), d + 28);
        push("s4_ch1",      ov(0, 3'b100, 0, 0, 0, 1), d + 33);
        push("s4_ch2",      ov(0, 3'b000, 0, 0, 0, 1), d + 38);
        push("s4_ready",    ov(0, 3'b000, 1, 0, 0, 1), d + 39);
        wait_until(d - 1); locked = 1'b0;
        wait_until(d);     locked = 1'b1;
        drain("s4_drain");

        // Timeout on first attempt, lock during second.
        do_reset("reset_s2", r);
        l = r + 118;
        push("s2_dcm_fall1", ov(0, 3'b111, 0, 0, 0, 0), r + 4);
        push("s2_timeout",   ov(1, 3'b111, 0, 1, 0, 0), r + 104);
        push("s2_dcm_fall2", ov(0, 3'b111, 0, 1, 0, 0), r + 108);
        push("s2_ch0",       ov(0, 3'b110, 0, 1, 0, 0), l + 23);
        push("s2_ch1",       ov(0, 3'b100, 0, 1, 0, 0), l + 28);
        push("s2_ch2",       ov(0, 3'b000, 0, 1, 0, 0), l + 33);
        push("s2_ready",     ov(0, 3'b000, 1, 0, 0, 0), l + 34);
        wait_until(l - 1); locked = 1'b1;
        drain("s2_drain");

        // Retry exhaustion: fail must hold until reset.
        do_reset("reset_s3", r);
        push("s3_dcm_fall1", ov(0, 3'b111, 0, 0, 0, 0), r + 4);
        push("s3_timeout1",  ov(1, 3'b111, 0, 1, 0, 0), r + 104);
        push("s3_dcm_fall2", ov(0, 3'b111, 0, 1, 0, 0), r + 108);
        push("s3_fail",      ov(1, 3'b111, 0, 2, 1, 0), r + 208);
        wait_until(r + 280);
        drain("s3_drain");

        // Glitch during SETTLE (locked low for edge L+11 only).
        do_reset("reset_s3_exit", r);
        l = r + 10;
        push("s5_dcm_fall1", ov(0, 3'b111, 0, 0, 0, 0), r + 4);
        push("s5_glitch",    ov(1, 3'b111, 0, 1, 0, 1), l + 13);
        push("s5_dcm_fall2", ov(0, 3'b111, 0, 1, 0, 1), l + 17);
        push("s5_ch0",       ov(0, 3'b110, 0, 1, 0, 1), l + 39);
        push("s5_ch1",       ov(0, 3'b100, 0, 1, 0, 1), l + 44);
        push("s5_ch2",       ov(0, 3'b000, 0, 1, 0, 1), l + 49);
        push("s5_ready",     ov(0, 3'b000, 1, 0, 0, 1), l + 50);
        wait_until(l - 1);  locked = 1'b1;
        wait_until(l + 10); locked = 1'b0;
        wait_until(l + 11); locked = 1'b1;
        drain("s5_drain");

        // Async reset while chan_rst = 100, then a clean restart.
        do_reset("reset_s6", r);
        l = r + 14;
        push("s6_dcm_fall", ov(0, 3'b111, 0, 0, 0, 0), r + 4);
        push("s6_ch0",      ov(0, 3'b110, 0, 0, 0, 0), l + 23);
        push("s6_ch1",      ov(0, 3'b100, 0, 0, 0, 0), l + 28);
        wait_until(l - 1); locked = 1'b1;
        wait_until(l + 30);
        drain("s6_drain");
        do_reset("reset_mid_release", r);
        push("s6_restart_dcm_fall", ov(0, 3'b111, 0, 0, 0, 0), r + 4);
        drain("s6_restart_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
